// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the core's execute stage to a word-addressed data memory. It takes
//   one byte, halfword or word load/store per request handshake. It returns
//   loads right-aligned and sign- or zero-extended. Sub-word stores are done
//   as a read-modify-write of the containing word.
//
// Memory port:
//   memRead is combinational (async read) from memAddr. The memory writes
//   memWriteData on the rising edge whenever memWriteEnable is high.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN
//     - defined:   misaligned halfword/word requests are rejected with respErr.
//     - undefined: the low address bits below the access size are ignored and
//                  the access proceeds as aligned.
//   Reserved size and out-of-range addresses are rejected in both builds.
//
// Parameters:
//   MEM_WORDS      number of 32-bit words behind the memory port
//
// Ports:
//   clk            clock
//   resetN         synchronous active-low reset
//   reqValid       request valid from the core
//   reqReady       unit idle and able to accept a request
//   reqWrite       1 = store, 0 = load
//   reqSize        0 byte, 1 halfword, 2 word, 3 reserved (error)
//   reqUnsigned    zero-extend sub-word loads
//   reqAddr        byte address
//   reqWData       store data, right-aligned
//   respValid      response valid
//   respReady      core accepts the response
//   respData       load result (0 for stores and errors)
//   respErr        access rejected
//   memAddr        word-aligned byte address to memory
//   memRead        combinational read data from memory
//   memWriteData   write data to memory
//   memWriteEnable memory write strobe
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respData,
    output logic        respErr,
    output logic [31:0] memAddr,
    input  logic [31:0] memRead,
    output logic [31:0] memWriteData,
    output logic        memWriteEnable
);

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_RSV = 2'd3;

    // One bit wider than the address so the limit itself is representable.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_t;

    // Control and registered outputs
    state_t      state_q;
    logic        respValid_q;
    logic        respErr_q;
    logic        memWe_q;
    logic [31:0] respData_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWriteData_q;

    // Latched request fields
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    // Combinational next values
    logic        accept;
    logic        misalign_d;
    logic        err_d;
    logic [1:0]  lane_d;
    logic [31:0] wordAddr_d;
    logic [31:0] loadData_d;
    logic [31:0] mergeData_d;

    // -------------------------------------------------------------------------
    // Lane helpers (little-endian: byte k is bits [8k+7:8k])
    // -------------------------------------------------------------------------
    function automatic logic [31:0] extract_lane(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  lane,
        input logic        uns
    );
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] sx;
        logic        [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h  = lane[1] ? word[31:16] : word[15:0];
        sb = signed'(b);
        sh = signed'(h);
        case (size)
            SIZE_B: begin
                sx  = 32'(sb);
                res = uns ? {24'd0, b} : sx;
            end
            SIZE_H: begin
                sx  = 32'(sh);
                res = uns ? {16'd0, h} : sx;
            end
            default: begin
                sx  = '0;
                res = word;
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(
        input logic [31:0] word,
        input logic [31:0] wdata,
        input logic [1:0]  size,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = word;
        if (size == SIZE_B) begin
            case (lane)
                2'd0:    res[7:0]   = wdata[7:0];
                2'd1:    res[15:8]  = wdata[7:0];
                2'd2:    res[23:16] = wdata[7:0];
                default: res[31:24] = wdata[7:0];
            endcase
        end else if (size == SIZE_H) begin
            if (lane[1]) res[31:16] = wdata[15:0];
            else         res[15:0]  = wdata[15:0];
        end else begin
            res = wdata;
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign reqReady = (state_q == ST_IDLE) & resetN;
    assign accept   = reqValid & reqReady;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_d = ((reqSize == SIZE_H) && reqAddr[0]) ||
                        ((reqSize == SIZE_W) && (reqAddr[1:0] != 2'b00));
`else
    assign misalign_d = 1'b0;
`endif

    assign err_d = (reqSize == SIZE_RSV) || misalign_d ||
                   ({1'b0, reqAddr} >= ADDR_LIMIT);

    // Bits below the access size are dropped, so a misaligned access that is
    // not trapped behaves exactly like the aligned one.
    always_comb begin
        lane_d = reqAddr[1:0];
        if (reqSize == SIZE_H)      lane_d = {reqAddr[1], 1'b0};
        else if (reqSize == SIZE_W) lane_d = 2'b00;
    end

    assign wordAddr_d  = {reqAddr[31:2], 2'b00};
    assign loadData_d  = extract_lane(memRead, size_q, lane_q, uns_q);
    assign mergeData_d = merge_lane(memRead, wdata_q, size_q, lane_q);

    // -------------------------------------------------------------------------
    // Request capture (data only; qualified by the handshake)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q  <= reqSize;
            uns_q   <= reqUnsigned;
            lane_q  <= lane_d;
            wdata_q <= reqWData;
        end
    end

    // -------------------------------------------------------------------------
    // Access FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q        <= ST_IDLE;
            respValid_q    <= 1'b0;
            respErr_q      <= 1'b0;
            memWe_q        <= 1'b0;
            respData_q     <= '0;
            memAddr_q      <= '0;
            memWriteData_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (err_d) begin
                            state_q     <= ST_RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            respData_q  <= '0;
                        end else if (!reqWrite) begin
                            state_q   <= ST_LOAD;
                            memAddr_q <= wordAddr_d;
                        end else if (reqSize == SIZE_W) begin
                            state_q        <= ST_WRITE;
                            memAddr_q      <= wordAddr_d;
                            memWe_q        <= 1'b1;
                            memWriteData_q <= reqWData;
                        end else begin
                            state_q   <= ST_RMW_RD;
                            memAddr_q <= wordAddr_d;
                        end
                    end
                end
                ST_LOAD: begin
                    state_q     <= ST_RESP;
                    respData_q  <= loadData_d;
                    respValid_q <= 1'b1;
                    memAddr_q   <= '0;
                end
                ST_RMW_RD: begin
                    // memAddr is held so the write lands on the word just read.
                    state_q        <= ST_WRITE;
                    memWriteData_q <= mergeData_d;
                    memWe_q        <= 1'b1;
                end
                ST_WRITE: begin
                    state_q     <= ST_RESP;
                    memWe_q     <= 1'b0;
                    memAddr_q   <= '0;
                    respValid_q <= 1'b1;
                    respData_q  <= '0;
                end
                ST_RESP: begin
                    if (respReady) begin
                        state_q     <= ST_IDLE;
                        respValid_q <= 1'b0;
                        respErr_q   <= 1'b0;
                        respData_q  <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign respValid      = respValid_q;
    assign respErr        = respErr_q;
    assign respData       = respData_q;
    assign memAddr        = memAddr_q;
    assign memWriteData   = memWriteData_q;
    // Gated so that asserting reset in WRITE suppresses that cycle's write.
    assign memWriteEnable = memWe_q & resetN;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 64;

    logic        clk;
    logic        resetN;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        respValid;
    logic        respReady;
    logic [31:0] respData;
    logic        respErr;
    logic [31:0] memAddr;
    logic [31:0] memRead;
    logic [31:0] memWriteData;
    logic        memWriteEnable;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk           (clk),
        .resetN        (resetN),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqWrite      (reqWrite),
        .reqSize       (reqSize),
        .reqUnsigned   (reqUnsigned),
        .reqAddr       (reqAddr),
        .reqWData      (reqWData),
        .respValid     (respValid),
        .respReady     (respReady),
        .respData      (respData),
        .respErr       (respErr),
        .memAddr       (memAddr),
        .memRead       (memRead),
        .memWriteData  (memWriteData),
        .memWriteEnable(memWriteEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory behind the port: async read, write on posedge.
    logic [31:0] mem [MEM_WORDS];
    int          wr_count;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;

    assign memRead = mem[memAddr[7:2]];

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
        wr_count   = 0;
        last_waddr = '0;
        last_wdata = '0;
        forever begin
            @(posedge clk);
            if (memWriteEnable === 1'b1) begin
                mem[memAddr[7:2]] <= memWriteData;
                wr_count   = wr_count + 1;
                last_waddr = memAddr;
                last_wdata = memWriteData;
            end
        end
    end

    // Reference model: memory image and access rules.
    int unsigned ref_mem [MEM_WORDS];

    int checks = 0;
    int errors = 0;

    logic [31:0] last_data;
    logic        last_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_err(input logic [1:0] sz, input logic [31:0] a);
        bit e;
        e = (sz == 2'd3) || (a >= 32'(MEM_WORDS * 4));
`ifdef LSU_MISALIGN_TRAP_EN
        if (sz == 2'd1 && (a % 2) != 0) e = 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        int unsigned w;
        int unsigned v;
        w = ref_mem[a / 4];
        if (sz == 2'd0) begin
            v = (w >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] waddr, output logic [31:0] wdata);
        int unsigned idx;
        int unsigned sh;
        int unsigned mask;
        idx = a / 4;
        if (sz == 2'd0) begin
            sh   = 8 * (a % 4);
            mask = 32'hFF << sh;
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh   = 16 * ((a / 2) % 2);
            mask = 32'hFFFF << sh;
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd & 32'hFFFF) << sh);
        end else begin
            ref_mem[idx] = wd;
        end
        waddr = idx * 4;
        wdata = ref_mem[idx];
    endtask

    // One complete transaction; called at a negedge. 'hold' is the number of
    // RESP cycles with respReady low, during which a stray request is driven.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit          e;
        int          exp_lat;
        int          lat;
        int          writes0;
        int          exp_writes;
        logic [31:0] exp_data;
        logic [31:0] exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] held_data;
        e         = exp_err(sz, a);
        exp_data  = '0;
        exp_waddr = '0;
        exp_wdata = '0;
        exp_writes = 0;
        if (e) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat  = 2;
            exp_data = exp_load(sz, uns, a);
        end else begin
            exp_lat    = (sz == 2'd2) ? 2 : 3;
            exp_writes = 1;
            model_store(sz, a, wd, exp_waddr, exp_wdata);
        end

        check("ready_idle", 32'(reqReady), 32'd1);
        reqValid    = 1'b1;
        reqWrite    = we;
        reqSize     = sz;
        reqUnsigned = uns;
        reqAddr     = a;
        reqWData    = wd;
        writes0     = wr_count;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request bus: the unit must work from latched fields.
        reqValid    = 1'b0;
        reqWrite    = 1'($urandom);
        reqSize     = 2'($urandom);
        reqUnsigned = 1'($urandom);
        reqAddr     = $urandom;
        reqWData    = $urandom;
        check("ready_busy", 32'(reqReady), 32'd0);
        lat = 1;
        while (respValid !== 1'b1 && lat < 8) begin
            respReady = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        respReady = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_err", 32'(respErr), 32'(e));
        check("resp_data", respData, exp_data);
        last_data = respData;
        last_err  = respErr;
        held_data = respData;

        for (int i = 0; i < hold; i++) begin
            reqValid = 1'b1;
            reqWrite = 1'b1;
            reqSize  = 2'd2;
            reqAddr  = 32'(4 * $urandom_range(0, MEM_WORDS - 1));
            @(negedge clk);
            check("hold_valid", 32'(respValid), 32'd1);
            check("hold_data", respData, held_data);
            check("hold_ready", 32'(reqReady), 32'd0);
        end
        reqValid = 1'b0;

        respReady = 1'b1;
        @(posedge clk);
        @(negedge clk);
        respReady = 1'b0;
        check("post_valid", 32'(respValid), 32'd0);
        check("post_data", respData, 32'd0);
        check("post_err", 32'(respErr), 32'd0);
        check("writes", 32'(wr_count - writes0), 32'(exp_writes));
        if (exp_writes == 1) begin
            check("wr_addr", last_waddr, exp_waddr);
            check("wr_data", last_wdata, exp_wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          wcount0;
        logic [1:0]  sz;
        logic [31:0] a;
        int          r;

        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 0;
        last_data   = '0;
        last_err    = 1'b0;
        resetN      = 1'b0;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqSize     = 2'd0;
        reqUnsigned = 1'b0;
        reqAddr     = '0;
        reqWData    = '0;
        respReady   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_respValid", 32'(respValid), 32'd0);
        check("rst_respErr", 32'(respErr), 32'd0);
        check("rst_memWE", 32'(memWriteEnable), 32'd0);
        check("rst_respData", respData, 32'd0);
        check("rst_memAddr", memAddr, 32'd0);
        check("rst_memWData", memWriteData, 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd0);
        resetN = 1'b1;
        @(negedge clk);

        // Word 0 = 0xC, load back
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h0000000C, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0);
        check("tp_lw0", last_data, 32'h0000000C);

        // Word 1 = 0x000080FF, sub-word loads
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h000080FF, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, 0);
        check("tp_lb4", last_data, 32'hFFFFFFFF);
        do_req(1'b0, 2'd1, 1'b1, 32'h4, 32'h0, 0);
        check("tp_lhu4", last_data, 32'h000080FF);
        do_req(1'b0, 2'd1, 1'b0, 32'h4, 32'h0, 0);
        check("tp_lh4", last_data, 32'hFFFF80FF);

        // Word 2 = 0x11223344, byte store 0xAB at 0xA
        do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'hA, 32'h000000AB, 0);
        check("tp_sb_addr", last_waddr, 32'h00000008);
        check("tp_sb_data", last_wdata, 32'h11AB3344);

        // Top word and first out-of-range address
        do_req(1'b1, 2'd2, 1'b0, 32'hFC, 32'hDEADBEEF, 0);
        check("tp_sw_top", last_waddr, 32'h000000FC);
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, 0);
        check("tp_oor_st", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd0, 1'b1, 32'h100, 32'h0, 0);
        check("tp_oor_ld", 32'(last_err), 32'd1);
        do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0);
        check("tp_rsv", 32'(last_err), 32'd1);

        // Misaligned halfword load at 0x3
        do_req(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("tp_mis_err", 32'(last_err), 32'd1);
`else
        check("tp_mis_err", 32'(last_err), 32'd0);
        check("tp_mis_data", last_data, 32'h00000000);
`endif
        do_req(1'b1, 2'd1, 1'b0, 32'h17, 32'h0000C0DE, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h16, 32'h0, 0);

        // Response held off for 5 cycles with stray requests
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 5);
        check("tp_hold_data", last_data, 32'h11AB3344);

        // Reset asserted during WRITE abandons the store
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqSize  = 2'd2;
        reqAddr  = 32'h20;
        reqWData = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        check("wr_state_memAddr", memAddr, 32'h00000020);
        resetN  = 1'b0;
        wcount0 = wr_count;
        #1;
        check("rst_wr_gate", 32'(memWriteEnable), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("rst_wr_count", 32'(wr_count - wcount0), 32'd0);
        check("rst_wr_valid", 32'(respValid), 32'd0);
        check("rst_wr_ready_low", 32'(reqReady), 32'd0);
        resetN = 1'b1;
        #1;
        check("rst_wr_ready", 32'(reqReady), 32'd1);
        @(negedge clk);
        do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);
        check("rst_wr_unchanged", last_data, 32'h00000000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 120; n++) begin
            r  = $urandom_range(0, 19);
            sz = (r == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if (r == 1)      a = 32'($urandom_range(256, 511));
            else if (r == 2) a = 32'hFFFFFFFC;
            else             a = 32'($urandom_range(0, 255));
            do_req(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        // Final memory image against the model
        for (int i = 0; i < MEM_WORDS; i++) begin
            check("mem_image", mem[i], ref_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
